// File: rtl/ttt2_pkg.sv
// Shared types for the ttt2 output-capture stage: widths, FSM states and FIFO entry layout.
package ttt2_pkg;

  localparam int PI_W = 24;
  localparam int PO_W = 21;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} cap_state_t;

  typedef struct packed {
    logic [PO_W-1:0] chg;
    logic [PO_W-1:0] data;
  } cap_entry_t;

endpackage

// File: rtl/ttt2_po_fifo.sv
// Synchronous first-word-fall-through FIFO of tagged capture entries.
// The head output holds the last popped entry while the FIFO is empty.
module ttt2_po_fifo
  import ttt2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  cap_entry_t wdata,
  output cap_entry_t rdata,
  output logic       full,
  output logic       empty,
  output logic       last
);

  localparam int AW = $clog2(DEPTH);

  cap_entry_t     mem_q [DEPTH];
  cap_entry_t     hold_q;
  logic [AW:0]    wptr_q;
  logic [AW:0]    rptr_q;
  logic [AW:0]    used;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer MSB separates full from empty; wrap-around is silent.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign used  = wptr_q - rptr_q;
  assign last  = (used == (AW+1)'(1));
  assign rdata = empty ? hold_q : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      hold_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop) begin
        hold_q <= mem_q[rptr_q[AW-1:0]];
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ttt2_po_capture.sv
// Capture stage for the ttt2 outputs: handshake sampling, change-mask tagging,
// FWFT buffering and a MISR signature over each run of N_SAMPLES vectors.
module ttt2_po_capture
  import ttt2_pkg::*;
#(
  parameter int                N_SAMPLES = 16,
  parameter int                DEPTH     = 4,
  parameter int                MISR_W    = 24,
  parameter logic [MISR_W-1:0] MISR_POLY = 24'h80000D,
  parameter logic [MISR_W-1:0] MISR_SEED = 24'h000000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [PO_W-1:0]                  po_vec,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PO_W-1:0]                  out_data,
  output logic [PO_W-1:0]                  out_chg,
  output logic [MISR_W-1:0]                misr,
  output logic [$clog2(N_SAMPLES+1)-1:0]   count,
  output logic                             busy,
  output logic                             done
);

  localparam int                CNT_W  = $clog2(N_SAMPLES+1);
  localparam logic [CNT_W-1:0]  N_LAST = CNT_W'(N_SAMPLES - 1);

  cap_state_t          state_q;
  logic [CNT_W-1:0]    count_q;
  logic [MISR_W-1:0]   misr_q;
  logic [PO_W-1:0]     last_vec_q;
  cap_entry_t          wdata;
  cap_entry_t          rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_last;
  logic                accept;
  logic                pop;

  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] s,
                                                  input logic [PO_W-1:0]   v);
    logic [MISR_W-1:0] fb;
    fb = s[MISR_W-1] ? MISR_POLY : '0;
    return {s[MISR_W-2:0], 1'b0} ^ fb ^ MISR_W'(v);
  endfunction

  // Ready is decoded from state and FIFO pointers only, never from in_valid.
  assign in_ready  = (state_q == CAPTURE) && !fifo_full;
  assign out_valid = !fifo_empty;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DRAIN) && (fifo_empty || (pop && fifo_last));

  assign wdata.chg  = po_vec ^ last_vec_q;
  assign wdata.data = po_vec;
  assign out_data   = rdata.data;
  assign out_chg    = rdata.chg;
  assign misr       = misr_q;
  assign count      = count_q;

  ttt2_po_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .last  (fifo_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      misr_q     <= MISR_SEED;
      last_vec_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= CAPTURE;
            count_q    <= '0;
            misr_q     <= MISR_SEED;
            last_vec_q <= '0;
          end
        end
        CAPTURE: begin
          if (accept) begin
            last_vec_q <= po_vec;
            count_q    <= count_q + 1'b1;
            misr_q     <= misr_next(misr_q, po_vec);
            if (count_q == N_LAST) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt2_po_capture.sv
// Directed bench for ttt2_po_capture with a cycle-level reference model and scoreboard.
module tb_ttt2_po_capture;

  localparam int N = 16;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [20:0] po_vec, out_data, out_chg;
  logic [23:0] misr;
  logic [4:0]  count;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  int          ms = 0;
  logic [41:0] q[$];
  logic [20:0] mlast = '0, hold_d = '0, hold_c = '0;
  logic [23:0] mmisr = '0;
  int          mcnt = 0;
  int          ndone = 0;
  int          nacc;
  logic [23:0] sv_misr;
  logic [4:0]  sv_cnt;

  always #5 clk = ~clk;

  ttt2_po_capture dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .po_vec    (po_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chg   (out_chg),
    .misr      (misr),
    .count     (count),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] misr_f(input logic [23:0] s, input logic [20:0] v);
    return {s[22:0], 1'b0} ^ (s[23] ? 24'h80000D : 24'h0) ^ {3'b000, v};
  endfunction

  // Check all outputs against the model, advance one clock, update the model.
  task automatic step();
    logic        exp_rdy, exp_done, acc, pp;
    logic [41:0] e;
    #1;
    exp_rdy = (ms == 1) && (q.size() < D);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0][20:0]);
      check("out_chg", out_chg, q[0][41:21]);
    end else begin
      check("hold_data", out_data, hold_d);
      check("hold_chg", out_chg, hold_c);
    end
    exp_done = (ms == 2) && (q.size() == 0 || (q.size() == 1 && out_ready));
    check("done", done, exp_done);
    check("busy", busy, ms != 0);
    check("count", count, mcnt);
    check("misr", misr, mmisr);
    if (done === 1'b1) ndone++;
    acc = in_valid && exp_rdy;
    pp  = (q.size() != 0) && out_ready;
    @(posedge clk);
    if (rst) begin
      ms = 0; q.delete(); hold_d = '0; hold_c = '0; mcnt = 0; mmisr = '0; mlast = '0;
    end else begin
      if (pp) begin
        e = q.pop_front();
        hold_d = e[20:0];
        hold_c = e[41:21];
      end
      case (ms)
        0: if (start) begin ms = 1; mcnt = 0; mmisr = '0; mlast = '0; end
        1: if (acc) begin
             q.push_back({po_vec ^ mlast, po_vec});
             mlast = po_vec;
             mcnt++;
             mmisr = misr_f(mmisr, po_vec);
             if (mcnt == N) ms = 2;
           end
        2: if (exp_done) ms = 0;
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic run_to_idle(input string tag, input bit rand_ready);
    for (int k = 0; k < 300 && ms != 0; k++) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      po_vec = 21'($urandom);
      step();
    end
    check(tag, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; po_vec = '0;
    repeat (2) @(posedge clk);
    #1;

    // 1: reset state
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_misr", misr, 24'h0);
    check("rst_count", count, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    step();

    // 2: MISR golden and change mask
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; po_vec = 21'h000001; step();
    check("gold_misr1", misr, 24'h000001);
    check("gold_chg1", out_chg, 21'h000001);
    po_vec = 21'h000002; step(); in_valid = 1'b0;
    check("gold_misr2", misr, 24'h000000);
    out_ready = 1'b1; step();
    check("gold_chg2", out_chg, 21'h000003);
    check("gold_data2", out_data, 21'h000002);
    step(); out_ready = 1'b0;

    // 3: backpressure fills exactly DEPTH entries
    in_valid = 1'b1; nacc = 0;
    for (int i = 0; i < 8; i++) begin
      po_vec = 21'h100 + 21'(i * 3);
      if (in_ready) nacc++;
      step();
    end
    check("bp_accepts", nacc, D);
    check("bp_full_ready", in_ready, 1'b0);
    out_ready = 1'b1; step();
    check("bp_resume", in_ready, 1'b1);
    run_to_idle("run1_idle", 1'b0);

    // 4: full run with random consumer
    start = 1'b1; step(); start = 1'b0;
    ndone = 0; in_valid = 1'b1;
    run_to_idle("run2_idle", 1'b1);
    check("run2_count", count, 5'd16);
    check("run2_done_once", ndone, 1);

    // 5: start ignored in CAPTURE and DRAIN
    out_ready = 1'b1; start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin po_vec = 21'($urandom); step(); end
    in_valid = 1'b0; #1;
    sv_misr = misr; sv_cnt = count;
    start = 1'b1; step(); start = 1'b0;
    check("s5_cap_count", count, sv_cnt);
    check("s5_cap_misr", misr, sv_misr);
    in_valid = 1'b1;
    for (int k = 0; k < 200 && ms == 1; k++) begin
      out_ready = (q.size() > 2);
      po_vec = 21'($urandom);
      step();
    end
    out_ready = 1'b0; in_valid = 1'b0; sv_misr = misr;
    start = 1'b1; step(); start = 1'b0;
    check("s5_drain_busy", busy, 1'b1);
    check("s5_drain_count", count, 5'd16);
    check("s5_drain_misr", misr, sv_misr);
    ndone = 0; out_ready = 1'b1;
    run_to_idle("s5_idle", 1'b0);
    repeat (3) step();
    check("s5_done_once", ndone, 1);

    // 6: reset mid-capture with two entries queued
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    po_vec = 21'h0ABCDE; step();
    po_vec = 21'h154321; step();
    in_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    check("r6_out_valid", out_valid, 1'b0);
    check("r6_busy", busy, 1'b0);
    check("r6_misr", misr, 24'h0);
    check("r6_count", count, 5'd0);
    start = 1'b1; step(); start = 1'b0;
    ndone = 0; in_valid = 1'b1; out_ready = 1'b1;
    run_to_idle("r6_idle", 1'b0);
    check("r6_count_end", count, 5'd16);
    check("r6_done_once", ndone, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
